// File: rtl/mux3x1_arb.sv
// Three-source round-robin arbiter driving a registered 3:1 data mux select.
// Define MUX3X1_ARB_HOLD_EN to enable HOLD-cycle preemption of a busy owner.
module mux3x1_arb #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    output logic gnt0,
    output logic gnt1,
    output logic gnt2,
    output logic s1,
    output logic s0,
    output logic busy,
    output logic y,
    output logic yv
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    if (HOLD < 1 || HOLD > 8) begin : g_hold_check
        $error("mux3x1_arb: HOLD must be in 1..8");
    end

    state_t     state_q, state_d;
    logic [1:0] own_q, own_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] req;
    logic [2:0] others;
    logic [1:0] win_idle;
    logic [1:0] win_hand;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Priority is p+1, p+2, then p itself (mod 3).
    function automatic logic [1:0] rr_pick(input logic [1:0] p,
                                           input logic [2:0] r);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = inc3(p);
        c2 = inc3(c1);
        if (r[c1])      return c1;
        else if (r[c2]) return c2;
        else            return p;
    endfunction

    assign req      = {req2, req1, req0};
    assign others   = req & ~(3'b001 << own_q);
    assign win_idle = rr_pick(own_q, req);
    assign win_hand = rr_pick(own_q, others);

`ifdef MUX3X1_ARB_HOLD_EN
    localparam logic [2:0] LIMIT = 3'(HOLD - 1);
    logic [2:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
`ifdef MUX3X1_ARB_HOLD_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    own_d   = win_idle;
`ifdef MUX3X1_ARB_HOLD_EN
                    cnt_d   = 3'd0;
`endif
                end
            end
            OWN: begin
                if (!req[own_q]) begin
                    if (|others) begin
                        own_d = win_hand;
`ifdef MUX3X1_ARB_HOLD_EN
                        cnt_d = 3'd0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef MUX3X1_ARB_HOLD_EN
                else if (cnt_q == LIMIT) begin
                    // Saturated: yield only if someone else is waiting.
                    if (|others) begin
                        own_d = win_hand;
                        cnt_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        gnt_d = (state_d == OWN) ? (3'b001 << own_d) : 3'b000;
        sel_d = (state_d == OWN) ? own_d : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= 2'd2;
            gnt_q   <= 3'b000;
            sel_q   <= 2'd0;
`ifdef MUX3X1_ARB_HOLD_EN
            cnt_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
`ifdef MUX3X1_ARB_HOLD_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign {gnt2, gnt1, gnt0} = gnt_q;
    assign {s1, s0}           = sel_q;
    assign busy               = (state_q == OWN);
    assign yv                 = busy;

    always_comb begin
        y = 1'b0;
        if (busy) begin
            unique case (sel_q)
                2'd0:    y = i0;
                2'd1:    y = i1;
                2'd2:    y = i2;
                default: y = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mux3x1_arb.sv
// Bench for mux3x1_arb: cycle model of the arbitration rules plus directed
// scenarios; builds with or without MUX3X1_ARB_HOLD_EN.
module tb_mux3x1_arb;

    localparam int HOLD = 4;
`ifdef MUX3X1_ARB_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] din = 3'b000;
    logic gnt0, gnt1, gnt2, s1, s0, busy, y, yv;

    int total = 0;
    int bad   = 0;

    mux3x1_arb #(.HOLD(HOLD)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .req2(req[2]),
        .i0(din[0]), .i1(din[1]), .i2(din[2]),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
        .s1(s1), .s0(s0), .busy(busy), .y(y), .yv(yv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: owner index (-1 = nobody), last grantee, cycles held so far.
    int  m_own  = -1;
    int  m_last = 2;
    int  m_held = 0;
    bit  m_ok   = 1'b0;

    always @(posedge clk) begin
        bit others;
        bit dropped;
        bit limit;
        if (rst) begin
            m_own = -1; m_last = 2; m_held = 0;
        end else if (m_own < 0) begin
            for (int k = 1; k <= 3; k++) begin
                if (m_own < 0 && req[(m_last + k) % 3]) begin
                    m_own = (m_last + k) % 3;
                end
            end
            if (m_own >= 0) begin
                m_last = m_own; m_held = 1;
            end
        end else begin
            others  = 1'b0;
            for (int j = 0; j < 3; j++)
                if (j != m_own && req[j]) others = 1'b1;
            dropped = !req[m_own];
            limit   = HOLD_EN && (m_held >= HOLD);
            if ((dropped || limit) && others) begin
                if (req[(m_own + 1) % 3]) m_own = (m_own + 1) % 3;
                else                      m_own = (m_own + 2) % 3;
                m_last = m_own; m_held = 1;
            end else if (dropped) begin
                m_own = -1;
            end else begin
                m_held++;
            end
        end
        m_ok = 1'b1;
    end

    always @(negedge clk) begin
        logic [2:0] eg;
        logic [1:0] es;
        logic       eb;
        logic       ey;
        if (m_ok) begin
            eg = (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
            es = (m_own >= 0) ? 2'(m_own) : 2'd0;
            eb = (m_own >= 0);
            ey = eb ? din[es] : 1'b0;
            chk("model_gnt",  {5'd0, gnt2, gnt1, gnt0}, {5'd0, eg});
            chk("model_sel",  {6'd0, s1, s0},           {6'd0, es});
            chk("model_busy", {6'd0, busy, yv},         {6'd0, eb, eb});
            chk("model_y",    {7'd0, y},                {7'd0, ey});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string nm, input logic [2:0] g,
                           input logic [1:0] s, input logic yy);
        chk({nm, "_gnt"}, {5'd0, gnt2, gnt1, gnt0}, {5'd0, g});
        chk({nm, "_sel"}, {6'd0, s1, s0}, {6'd0, s});
        chk({nm, "_busy"}, {6'd0, busy, yv}, {6'd0, |g, |g});
        chk({nm, "_y"}, {7'd0, y}, {7'd0, yy});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 3'b111; din = 3'b111;
        repeat (2) begin
            tick();
            exp_out("reset", 3'b000, 2'd0, 1'b0);
        end
        rst = 1'b0; req = 3'b000;
        tick();
        exp_out("idle", 3'b000, 2'd0, 1'b0);

        // Single request on source 1.
        din = 3'b101; req = 3'b010;
        repeat (3) begin
            tick();
            exp_out("single1", 3'b010, 2'd1, 1'b0);
        end
        req = 3'b000;
        tick();
        exp_out("single1_rel", 3'b000, 2'd0, 1'b0);

        // Owner 0 drops at count 1 while 2 waits.
        din = 3'b110; req = 3'b001;
        tick();
        exp_out("hand_own0", 3'b001, 2'd0, 1'b0);
        req = 3'b101;
        tick();
        exp_out("hand_cnt1", 3'b001, 2'd0, 1'b0);
        req = 3'b100;
        tick();
        exp_out("hand_to2", 3'b100, 2'd2, 1'b1);
        req = 3'b000;
        tick();
        exp_out("hand_rel", 3'b000, 2'd0, 1'b0);

`ifdef MUX3X1_ARB_HOLD_EN
        // All request: 0,1,2,0 each HOLD cycles, no gaps.
        din = 3'b010; req = 3'b111;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_out("rr", 3'b001 << ((k / 4) % 3), 2'((k / 4) % 3),
                    ((k / 4) % 3) == 1);
        end
        req = 3'b000;
        tick();
        exp_out("rr_rel", 3'b000, 2'd0, 1'b0);

        // Lone requester keeps grant past HOLD; next requester preempts.
        din = 3'b001; req = 3'b001;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_out("sat", 3'b001, 2'd0, 1'b1);
        end
        req = 3'b011;
        tick();
        exp_out("sat_pre", 3'b010, 2'd1, 1'b0);
        req = 3'b000;
        tick();
        exp_out("sat_rel", 3'b000, 2'd0, 1'b0);
`else
        // No preemption: owner 0 holds as long as it requests.
        din = 3'b011; req = 3'b111;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_out("nohold", 3'b001, 2'd0, 1'b1);
        end
        req = 3'b110;
        tick();
        exp_out("nohold_drop", 3'b010, 2'd1, 1'b1);
        req = 3'b000;
        tick();
        exp_out("nohold_rel", 3'b000, 2'd0, 1'b0);
`endif

        // Reset mid-grant, then first arbitration restarts at source 0.
        din = 3'b111; req = 3'b010;
        tick();
        exp_out("mid_own", 3'b010, 2'd1, 1'b1);
        rst = 1'b1; req = 3'b111;
        tick();
        exp_out("mid_rst", 3'b000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        exp_out("post_rst", 3'b001, 2'd0, 1'b1);
        req = 3'b000;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
